operand_stage: RTL and testbench

ID/EX boundary of the 8-bit MIPS pipeline, directly downstream of the 8×8 register file. Each cycle it takes the decoded instruction and the two register-file read ports. It resolves operand values by forwarding from EX/MEM and MEM/WB, detects load-use hazards and stalls decode, and registers the result into the EX stage. It also handles branch flushes and keeps a saturating stall counter for debug.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/forward_mux.sv | 33 +++
 rtl/operand_stage.sv | 151 +++++++++++++++
 tb/tb_operand_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS pipeline: widths, ALU encodings and
// the control bundle that travels from decode into EX.
package mips_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       use_imm;
  } ctrl_t;

  // A bubble carries no side effects: it never reads/writes memory or registers.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_mux.sv
// Resolves one source operand: R0 is zero, then EX/MEM, then MEM/WB, then
// the register file read data.
module forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] value
);

  // The register file only updates on the edge, so the WB value must be
  // bypassed here rather than read back through rf_data.
  always_comb begin
    value = rf_data;
    if (idx == '0) begin
      value = '0;
    end else if (exm_reg_write && (exm_rd == idx)) begin
      value = exm_result;
    end else if (wb_reg_write && (wb_rd == idx)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX boundary: operand forwarding, load-use stall detection, branch-flush
// bubbles, the EX pipeline register and a saturating stall counter.
module operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_op,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rd,
  output logic [2:0]        ex_alu_op,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_use_imm,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  ctrl_t             ctrl_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic              hazard_p0;
  logic              vld_p0;

  ctrl_t             ctrl_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_W-1:0]  rd_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // ---- Stage p0: decode-side operand resolution and hazard detection ----
  assign ctrl_p0 = '{alu_op:    id_alu_op,
                     mem_read:  id_mem_read,
                     mem_write: id_mem_write,
                     reg_write: id_reg_write,
                     use_imm:   id_use_imm};

  forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_a (
    .idx           (id_rs),
    .rf_data       (rf_data_1),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .value         (a_p0)
  );

  forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_b (
    .idx           (id_rt),
    .rf_data       (rf_data_2),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .value         (b_p0)
  );

  // Load data is not ready until MEM/WB, so a dependent instruction directly
  // behind a load must wait one cycle. A flush kills the instruction anyway.
  always_comb begin
    hazard_p0 = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) &&
                ((id_use_rs && (id_rs == rd_p1)) ||
                 (id_use_rt && (id_rt == rd_p1)));
    id_stall  = id_valid && hazard_p0 && !flush;
    vld_p0    = id_valid && !id_stall && !flush;
  end

  // ---- Stage p1: EX pipeline register and stall counter ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_BUBBLE;
      a_p1    <= '0;
      b_p1    <= '0;
      imm_p1  <= '0;
      rd_p1   <= '0;
      cnt_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      cnt_p1 <= sat_inc(cnt_p1, id_stall);
      if (vld_p0) begin
        ctrl_p1 <= ctrl_p0;
        a_p1    <= a_p0;
        b_p1    <= b_p0;
        imm_p1  <= id_imm;
        rd_p1   <= id_rd;
      end else begin
        ctrl_p1 <= CTRL_BUBBLE;
        a_p1    <= '0;
        b_p1    <= '0;
        imm_p1  <= '0;
        rd_p1   <= '0;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_a         = a_p1;
  assign ex_b         = b_p1;
  assign ex_imm       = imm_p1;
  assign ex_rd        = rd_p1;
  assign ex_alu_op    = ctrl_p1.alu_op;
  assign ex_mem_read  = ctrl_p1.mem_read;
  assign ex_mem_write = ctrl_p1.mem_write;
  assign ex_reg_write = ctrl_p1.reg_write;
  assign ex_use_imm   = ctrl_p1.use_imm;
  assign stall_count  = cnt_p1;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: forwarding table, load-use/flush/reset
// sequences, counter saturation and randomized traffic against a reference model.
module tb_operand_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [2:0] id_rs, id_rt, id_rd, id_alu_op;
  logic [7:0] id_imm, rf_data_1, rf_data_2;
  logic       id_mem_read, id_mem_write, id_reg_write, id_use_imm;
  logic [2:0] exm_rd, wb_rd;
  logic       exm_reg_write, wb_reg_write;
  logic [7:0] exm_result, wb_data;
  logic       flush;
  logic       id_stall, ex_valid;
  logic [7:0] ex_a, ex_b, ex_imm;
  logic [2:0] ex_rd, ex_alu_op;
  logic       ex_mem_read, ex_mem_write, ex_reg_write, ex_use_imm;
  logic [7:0] stall_count;

  operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_use_imm(id_use_imm), .rf_data_1(rf_data_1),
    .rf_data_2(rf_data_2), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_use_imm(ex_use_imm), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: contents of the EX slot and the stall tally.
  typedef struct {
    bit       v;
    bit [7:0] a, b, imm;
    bit [2:0] rd, op;
    bit       mr, mw, rw, ui;
  } ex_t;
  ex_t m;
  int  m_cnt;

  typedef struct {
    bit [2:0] rs;
    bit [2:0] xrd;  bit xrw; bit [7:0] xres;
    bit [2:0] wrd;  bit wrw; bit [7:0] wdat;
    bit [7:0] rf1;
    bit [7:0] exp_a;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit [7:0] resolve(bit [2:0] idx, bit [7:0] rf);
    if (idx == 0) return 8'h00;
    if (exm_reg_write && exm_rd == idx) return exm_result;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m = '{default: 0};
    m_cnt = 0;
  endtask

  task automatic compare_all();
    chk("ex_valid", ex_valid, m.v);
    chk("ex_a", ex_a, m.a);
    chk("ex_b", ex_b, m.b);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_alu_op", ex_alu_op, m.op);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_use_imm", ex_use_imm, m.ui);
    chk("stall_count", stall_count, m_cnt);
  endtask

  // Inputs are set by the caller; check the stall, advance the model, clock, compare.
  task automatic step();
    bit  st;
    ex_t n;
    #1;
    st = !flush && id_valid && m.v && m.mr && m.rd != 0 &&
         ((id_use_rs && id_rs == m.rd) || (id_use_rt && id_rt == m.rd));
    chk("id_stall", id_stall, st);
    n = '{default: 0};
    if (id_valid && !st && !flush) begin
      n.v = 1; n.a = resolve(id_rs, rf_data_1); n.b = resolve(id_rt, rf_data_2);
      n.imm = id_imm; n.rd = id_rd; n.op = id_alu_op;
      n.mr = id_mem_read; n.mw = id_mem_write; n.rw = id_reg_write; n.ui = id_use_imm;
    end
    if (st && m_cnt < 255) m_cnt++;
    m = n;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_imm = 0; id_alu_op = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    id_use_imm = 0; rf_data_1 = 0; rf_data_2 = 0; exm_rd = 0; exm_reg_write = 0;
    exm_result = 0; wb_rd = 0; wb_reg_write = 0; wb_data = 0; flush = 0;
  endtask

  task automatic random_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs = 3'($urandom_range(0, 7)); id_rt = 3'($urandom_range(0, 7));
    id_rd = 3'($urandom_range(0, 7));
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    id_imm = 8'($urandom); id_alu_op = 3'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
    id_reg_write = 1'($urandom); id_use_imm = 1'($urandom);
    rf_data_1 = 8'($urandom); rf_data_2 = 8'($urandom);
    exm_rd = 3'($urandom_range(0, 7)); exm_reg_write = 1'($urandom);
    exm_result = 8'($urandom);
    wb_rd = 3'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
    wb_data = 8'($urandom);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic set_load_r5();
    idle_inputs();
    id_valid = 1; id_rs = 1; id_rd = 5; id_use_rs = 1;
    id_mem_read = 1; id_reg_write = 1; id_use_imm = 1; id_imm = 8'h04;
  endtask

  task automatic set_add_r5(input bit use_rt_only_as_rs);
    idle_inputs();
    id_valid = 1; id_rd = 6; id_reg_write = 1; id_alu_op = 3'd0;
    rf_data_1 = 8'h10; rf_data_2 = 8'h20;
    if (use_rt_only_as_rs) begin
      id_rs = 2; id_rt = 5; id_use_rs = 1; id_use_rt = 0;
    end else begin
      id_rs = 5; id_rt = 2; id_use_rs = 1; id_use_rt = 1;
    end
  endtask

  vec_t vecs[7];
  int   cnt0;

  initial begin
    vecs[0] = '{3'd3, 3'd3, 1'b1, 8'h11, 3'd3, 1'b1, 8'h22, 8'h33, 8'h11};
    vecs[1] = '{3'd3, 3'd3, 1'b0, 8'h11, 3'd3, 1'b1, 8'h22, 8'h33, 8'h22};
    vecs[2] = '{3'd3, 3'd3, 1'b0, 8'h11, 3'd3, 1'b0, 8'h22, 8'h33, 8'h33};
    vecs[3] = '{3'd0, 3'd0, 1'b1, 8'hFF, 3'd0, 1'b1, 8'hEE, 8'h77, 8'h00};
    vecs[4] = '{3'd6, 3'd2, 1'b1, 8'hA1, 3'd6, 1'b1, 8'hB2, 8'hC3, 8'hB2};
    vecs[5] = '{3'd7, 3'd7, 1'b1, 8'h5A, 3'd1, 1'b1, 8'h6B, 8'h7C, 8'h5A};
    vecs[6] = '{3'd4, 3'd4, 1'b0, 8'h01, 3'd4, 1'b0, 8'h02, 8'h9D, 8'h9D};

    // Reset held with toggling inputs
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      random_inputs();
      @(posedge clk); #1;
      chk("reset_id_stall", id_stall, 0);
      compare_all();
    end
    idle_inputs();
    rst = 1'b1;
    id_valid = 1; id_rs = 2; id_rt = 3; id_rd = 4; id_imm = 8'h5C;
    rf_data_1 = 8'h12; rf_data_2 = 8'h34; id_reg_write = 1; id_alu_op = 3'd1;
    step();
    chk("first_after_reset_valid", ex_valid, 1);
    chk("first_after_reset_b", ex_b, 8'h34);

    // Forwarding priority table
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      id_valid = 1; id_use_rs = 1; id_rd = 1; id_rs = vecs[i].rs;
      exm_rd = vecs[i].xrd; exm_reg_write = vecs[i].xrw; exm_result = vecs[i].xres;
      wb_rd = vecs[i].wrd; wb_reg_write = vecs[i].wrw; wb_data = vecs[i].wdat;
      rf_data_1 = vecs[i].rf1;
      step();
      chk($sformatf("fwd_a[%0d]", i), ex_a, vecs[i].exp_a);
    end

    // Load-use: exactly one stall cycle then the add proceeds
    set_load_r5(); step();
    set_add_r5(0);
    cnt0 = m_cnt;
    #1 chk("load_use_stall", id_stall, 1);
    step();
    chk("load_use_bubble_valid", ex_valid, 0);
    chk("load_use_bubble_rw", ex_reg_write, 0);
    chk("load_use_count", stall_count, cnt0 + 1);
    wb_rd = 5; wb_reg_write = 1; wb_data = 8'hD5;
    #1 chk("load_use_released", id_stall, 0);
    step();
    chk("load_use_fwd_wb", ex_a, 8'hD5);

    // Dependent register only named in an unused rt field: no stall
    set_load_r5(); step();
    set_add_r5(1);
    #1 chk("unused_rt_no_stall", id_stall, 0);
    step();

    // Flush during a hazard
    set_load_r5(); step();
    set_add_r5(0); flush = 1;
    cnt0 = m_cnt;
    #1 chk("flush_no_stall", id_stall, 0);
    step();
    chk("flush_bubble", ex_valid, 0);
    chk("flush_count", stall_count, cnt0);
    idle_inputs(); step();

    // Reset mid-stall: asynchronous, clears everything before any edge
    set_load_r5(); step();
    set_add_r5(0);
    #1 chk("pre_reset_stall", id_stall, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_valid", ex_valid, 0);
    chk("async_reset_mem_read", ex_mem_read, 0);
    chk("async_reset_count", stall_count, 0);
    chk("async_reset_stall", id_stall, 0);
    model_reset();
    @(posedge clk); #1;
    compare_all();
    idle_inputs();
    rst = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      step();
    end

    // Saturation: a load that depends on its own destination stalls every other cycle
    idle_inputs(); step();
    set_load_r5(); id_rs = 5;
    for (int i = 0; i < 620; i++) step();
    chk("sat_255", stall_count, 255);
    for (int i = 0; i < 20; i++) step();
    chk("sat_hold", stall_count, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
